misc_op_stash: RTL and testbench

//  Upstream feeder for the MISC opcode decoder. Accepts instruction words over a

---
 rtl/misc_op_pkg.sv | 32 +++
 rtl/misc_op_decode.sv | 36 +++
 rtl/misc_op_stash.sv | 124 ++++++++++++
 tb/tb_misc_op_stash.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/misc_op_pkg.sv
// Shared types for the MISC opcode stash: opcode patterns, decode encoding,
// buffered entry layout and the FIFO occupancy states.
package misc_op_pkg;

  // Representative values of the MISC opcode groups. MISC0X covers 3'b00?
  // and MISC1X covers 3'b10?; the decoder expands these into wildcards.
  typedef enum logic [2:0] {
    MISC0  = 3'b000,
    MISC0X = 3'b001,
    MISC1X = 3'b100
  } MiscOpcode_e;

  typedef logic [1:0] misc_dec_t;

  localparam misc_dec_t DEC_MISC0  = 2'b11;
  localparam misc_dec_t DEC_MISC0X = 2'b10;
  localparam misc_dec_t DEC_MISC1X = 2'b00;

  // One buffered word: raw opcode field plus the decode made at push time.
  typedef struct packed {
    logic [2:0] stash;
    misc_dec_t  opcode;
    logic       illegal;
  } misc_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } misc_occ_e;

endpackage

// File: rtl/misc_op_decode.sv
// Combinational MISC opcode decoder: 3-bit opcode field -> {opcode, illegal}.
module misc_op_decode
  import misc_op_pkg::*;
(
  input  logic [2:0] stash_i,
  output misc_dec_t  opcode_o,
  output logic       illegal_o
);

  // First-match priority: 000 beats 00?. The items are written in priority
  // order and 000 is carved out of the 00? group so that at most one item
  // can ever match, keeping the unique0 check meaningful.
  always_comb begin
    opcode_o  = DEC_MISC1X;
    illegal_o = 1'b1;
    unique0 case (stash_i) inside
      MISC0: begin
        opcode_o  = DEC_MISC0;
        illegal_o = 1'b0;
      end
      3'b001: begin
        opcode_o  = DEC_MISC0X;
        illegal_o = 1'b0;
      end
      3'b10?: begin
        opcode_o  = DEC_MISC1X;
        illegal_o = 1'b0;
      end
      default: begin
        opcode_o  = DEC_MISC1X;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/misc_op_stash.sv
// MISC opcode stash: 2-entry skid FIFO of decoded opcode fields with a
// valid/ready interface on both sides and a saturating illegal-opcode counter.
module misc_op_stash
  import misc_op_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int OPC_LSB = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_stash,
  output logic [1:0]        out_opcode,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  misc_occ_e        occ_q;
  logic             in_ready_q;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  misc_entry_t      mem_q [2];
  misc_entry_t      new_entry;
  misc_entry_t      head;
  logic             push;
  logic             pop;
  misc_dec_t        dec_opcode;
  logic             dec_illegal;
  logic             unused_word_bits;

  // Only the opcode field of the word is stored; the rest is dropped.
  assign unused_word_bits = ^in_word;

  misc_op_decode u_decode (
    .stash_i   (in_word[OPC_LSB +: 3]),
    .opcode_o  (dec_opcode),
    .illegal_o (dec_illegal)
  );

  assign new_entry = '{stash: in_word[OPC_LSB +: 3], opcode: dec_opcode, illegal: dec_illegal};

  assign in_ready  = in_ready_q;
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Occupancy FSM; in_ready is registered alongside it as !FULL of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (push) occ_q <= OCC_ONE;
        end
        OCC_ONE: begin
          if (push && !pop) begin
            occ_q      <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            occ_q <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            occ_q      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          occ_q      <= OCC_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Read and write pointers advance on pop and push; 1-bit wrap is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push) wr_ptr_q <= ~wr_ptr_q;
    end
  end

  // Entry storage holds data only; validity comes from the occupancy state.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign cnt_d = (push && dec_illegal) ? sat_inc(cnt_q) : cnt_q;

  // Illegal opcodes are counted as they are accepted, not as they leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign illegal_count = cnt_q;

  // Outputs read zero while empty, so stale or uninitialised storage never shows.
  assign head        = mem_q[rd_ptr_q];
  assign out_stash   = out_valid ? head.stash   : 3'b000;
  assign out_opcode  = out_valid ? head.opcode  : 2'b00;
  assign out_illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_misc_op_stash.sv
// Scoreboard bench for misc_op_stash: the driver queues hand-computed expected
// entries on acceptance, a monitor pops and compares on every consumed output.
module tb_misc_op_stash;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_stash;
  logic [1:0]  out_opcode;
  logic        out_illegal;
  logic [7:0]  illegal_count;

  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] in_word2;
  logic        out_valid2;
  logic [2:0]  out_stash2;
  logic [1:0]  out_opcode2;
  logic        out_illegal2;
  logic [1:0]  illegal_count2;

  int errors = 0;
  int checks = 0;
  logic [5:0] expq [$];

  always #5 clk = ~clk;

  misc_op_stash #(.WORD_W(16), .OPC_LSB(0), .CNT_W(8)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_word       (in_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_stash     (out_stash),
    .out_opcode    (out_opcode),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
  );

  misc_op_stash #(.WORD_W(16), .OPC_LSB(0), .CNT_W(2)) u_dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid2),
    .in_ready      (in_ready2),
    .in_word       (in_word2),
    .out_valid     (out_valid2),
    .out_ready     (1'b1),
    .out_stash     (out_stash2),
    .out_opcode    (out_opcode2),
    .out_illegal   (out_illegal2),
    .illegal_count (illegal_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle offer of a word; queued as expected output only if accepted.
  task automatic push_word(input logic [2:0] stash, input logic [1:0] eopc,
                           input logic eill, output bit acc);
    logic [12:0] filler;
    filler   = 13'($urandom);
    in_valid = 1'b1;
    in_word  = {filler, stash};
    acc      = in_ready;
    if (acc) expq.push_back({stash, eopc, eill});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: compare every consumed head entry against the scoreboard.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_output", {26'd0, out_stash, out_opcode, out_illegal}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("out_stash",   {29'd0, out_stash},   {29'd0, e[5:3]});
          check("out_opcode",  {30'd0, out_opcode},  {30'd0, e[2:1]});
          check("out_illegal", {31'd0, out_illegal}, {31'd0, e[0]});
        end
      end
    end
  end

  initial begin
    bit acc;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    in_valid2 = 1'b0;
    in_word2  = '0;
    #12;
    check("rst_in_ready",    {31'd0, in_ready},    32'd1);
    check("rst_out_valid",   {31'd0, out_valid},   32'd0);
    check("rst_out_stash",   {29'd0, out_stash},   32'd0);
    check("rst_out_opcode",  {30'd0, out_opcode},  32'd0);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_count",       {24'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word, one-cycle latency
    out_ready = 1'b1;
    push_word(3'b101, 2'b00, 1'b0, acc);
    check("t1_accept",    {31'd0, acc},       32'd1);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_stash", {29'd0, out_stash}, 32'd5);
    @(negedge clk);

    // 2: back-to-back words, no bubbles, priority of 000 over 00?
    push_word(3'b000, 2'b11, 1'b0, acc);
    check("t2_valid0", {31'd0, out_valid}, 32'd1);
    push_word(3'b001, 2'b10, 1'b0, acc);
    check("t2_valid1", {31'd0, out_valid}, 32'd1);
    push_word(3'b100, 2'b00, 1'b0, acc);
    check("t2_valid2", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check("t2_drained", {31'd0, out_valid}, 32'd0);

    // 3: stall fills to two entries, third offer refused, head stable
    out_ready = 1'b0;
    push_word(3'b101, 2'b00, 1'b0, acc);
    check("t3_acc1", {31'd0, acc}, 32'd1);
    push_word(3'b000, 2'b11, 1'b0, acc);
    check("t3_acc2", {31'd0, acc}, 32'd1);
    check("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
    push_word(3'b001, 2'b10, 1'b0, acc);
    check("t3_acc3_refused", {31'd0, acc}, 32'd0);
    @(negedge clk);
    check("t3_stable_stash",  {29'd0, out_stash},  32'd5);
    check("t3_stable_opcode", {30'd0, out_opcode}, 32'd0);
    check("t3_stable_valid",  {31'd0, out_valid},  32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t3_drained", {31'd0, out_valid}, 32'd0);
    check("t3_in_ready", {31'd0, in_ready}, 32'd1);

    // 4: illegal opcodes and counter
    push_word(3'b010, 2'b00, 1'b1, acc);
    push_word(3'b111, 2'b00, 1'b1, acc);
    check("t4_count2", {24'd0, illegal_count}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      in_word2  = {13'h1ABC, (i % 2 == 0) ? 3'b110 : 3'b011};
      check("t4_in_ready2", {31'd0, in_ready2}, 32'd1);
      @(negedge clk);
      if (i == 2) check("t4_cnt2_at3", {30'd0, illegal_count2}, 32'd3);
    end
    in_valid2 = 1'b0;
    check("t4_cnt2_sat", {30'd0, illegal_count2}, 32'd3);

    // 5: one entry held, simultaneous push and pop keeps occupancy at one
    out_ready = 1'b0;
    push_word(3'b100, 2'b00, 1'b0, acc);
    out_ready = 1'b1;
    push_word(3'b001, 2'b10, 1'b0, acc);
    check("t5_acc", {31'd0, acc}, 32'd1);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_out_valid", {31'd0, out_valid}, 32'd1);
    check("t5_head_stash", {29'd0, out_stash}, 32'd1);
    check("t5_head_opcode", {30'd0, out_opcode}, 32'd2);
    @(negedge clk);
    check("t5_empty_after", {31'd0, out_valid}, 32'd0);

    // 6: asynchronous reset while full
    out_ready = 1'b0;
    push_word(3'b010, 2'b00, 1'b1, acc);
    push_word(3'b000, 2'b11, 1'b0, acc);
    check("t6_full", {31'd0, in_ready}, 32'd0);
    check("t6_count3", {24'd0, illegal_count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_count", {24'd0, illegal_count}, 32'd0);
    check("t6_out_stash", {29'd0, out_stash}, 32'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    push_word(3'b101, 2'b00, 1'b0, acc);
    check("t6_recover_acc", {31'd0, acc}, 32'd1);

    n = 0;
    while (expq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("scoreboard_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
